// File: rtl/ads78xx_multi_rx.sv
// Multi-channel receiver for ADS7822-class serial ADCs: one shared conversion clock and chip
// select, one data line per converter, all channels captured in a single frame.
module ads78xx_multi_rx #(
    parameter int CH_NUM    = 3,
    parameter int DATA_W    = 12,
    parameter int LEAD      = 3,
    parameter int DIV       = 40,
    parameter int SAMPLE_DC = DIV / 2 + 3,
    parameter int PERIOD    = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trigger_i,
    input  logic                       auto_en_i,
    input  logic [CH_NUM-1:0]          ad_dout_i,
    output logic                       ad_clk_o,
    output logic                       ad_cs_n_o,
    output logic [CH_NUM*DATA_W-1:0]   sample_data_o,
    output logic                       data_valid_o,
    output logic                       busy_o,
    output logic                       overrun_o
);

    localparam int NBITS = LEAD + DATA_W;
    localparam int DcW   = $clog2(DIV);
    localparam int BcW   = $clog2(NBITS);
    localparam int PcW   = $clog2(PERIOD);

    localparam logic [DcW-1:0] DcLast   = DcW'(DIV - 1);
    localparam logic [DcW-1:0] DcHalfM1 = DcW'(DIV / 2 - 1);
    localparam logic [DcW-1:0] DcSample = DcW'(SAMPLE_DC);
    localparam logic [BcW-1:0] BcLast   = BcW'(NBITS - 1);
    localparam logic [PcW-1:0] PcLast   = PcW'(PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    logic                     trig_s1_q, trig_s2_q, trig_prev_q, trig_req_q;
    logic [CH_NUM-1:0]        dout_s1_q, dout_s2_q;
    logic [PcW-1:0]           pcnt_q;
    logic                     tick, start_req, capture;

    state_e                   state_q;
    logic [DcW-1:0]           dc_q;
    logic [BcW-1:0]           bc_q;
    logic                     ad_clk_q, cs_n_q, busy_q, dv_q, ovr_q;
    logic [CH_NUM*DATA_W-1:0] sr_q, sr_d, data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_prev_q <= 1'b0;
            trig_req_q  <= 1'b0;
            dout_s1_q   <= '0;
            dout_s2_q   <= '0;
            pcnt_q      <= '0;
        end else begin
            trig_s1_q   <= trigger_i;
            trig_s2_q   <= trig_s1_q;
            trig_prev_q <= trig_s2_q;
            trig_req_q  <= trig_s2_q & ~trig_prev_q;
            dout_s1_q   <= ad_dout_i;
            dout_s2_q   <= dout_s1_q;
            if (!auto_en_i || pcnt_q == PcLast) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_q + 1'b1;
            end
        end
    end

    assign tick      = auto_en_i && (pcnt_q == PcLast);
    assign start_req = trig_req_q | tick;
    // Lead periods (sample window and null bit) are clocked but never shifted in.
    assign capture   = (state_q == StShift) && (dc_q == DcSample) && (int'(bc_q) >= LEAD);

    always_comb begin
        sr_d = sr_q;
        if (capture) begin
            for (int k = 0; k < CH_NUM; k++) begin
                sr_d[k*DATA_W +: DATA_W] = {sr_q[k*DATA_W +: DATA_W-1], dout_s2_q[k]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            dc_q     <= '0;
            bc_q     <= '0;
            ad_clk_q <= 1'b0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            dv_q     <= 1'b0;
            ovr_q    <= 1'b0;
            sr_q     <= '0;
            data_q   <= '0;
        end else begin
            dv_q  <= 1'b0;
            ovr_q <= start_req && (state_q != StIdle);
            sr_q  <= sr_d;
            unique case (state_q)
                StIdle: begin
                    if (start_req) begin
                        state_q <= StSetup;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        dc_q    <= '0;
                        bc_q    <= '0;
                        sr_q    <= '0;
                    end
                end
                StSetup: begin
                    if (dc_q == DcLast) begin
                        dc_q    <= '0;
                        state_q <= StShift;
                    end else begin
                        dc_q <= dc_q + 1'b1;
                    end
                end
                StShift: begin
                    if (dc_q == DcLast) begin
                        dc_q     <= '0;
                        ad_clk_q <= 1'b0;
                        if (bc_q == BcLast) begin
                            bc_q    <= '0;
                            state_q <= StHold;
                            cs_n_q  <= 1'b1;
                            // sr_d so a capture on the final cycle still lands in the result
                            data_q  <= sr_d;
                            dv_q    <= 1'b1;
                        end else begin
                            bc_q <= bc_q + 1'b1;
                        end
                    end else begin
                        dc_q     <= dc_q + 1'b1;
                        ad_clk_q <= (dc_q >= DcHalfM1);
                    end
                end
                StHold: begin
                    if (dc_q == DcLast) begin
                        dc_q    <= '0;
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        dc_q <= dc_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ad_clk_o      = ad_clk_q;
    assign ad_cs_n_o     = cs_n_q;
    assign sample_data_o = data_q;
    assign data_valid_o  = dv_q;
    assign busy_o        = busy_q;
    assign overrun_o     = ovr_q;

endmodule
